// File: rtl/sqrt_iter.sv
// sqrt_iter: digit-recurrence square root retiring one root bit per clock,
// with ready/valid on both sides, output backpressure and synchronous abort.
module sqrt_iter #(
    parameter int WIDTH     = 12,
    parameter int FRAC_BITS = 0
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [WIDTH-1:0]              x_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          abort_in,
    output logic [WIDTH/2+FRAC_BITS-1:0]  root_out,
    output logic [WIDTH/2+FRAC_BITS:0]    rem_out,
    output logic                          exact_out,
    output logic                          valid_out,
    input  logic                          ready_in
);
    localparam int RW  = WIDTH/2 + FRAC_BITS;
    localparam int SHW = 2*RW;
    localparam int CW  = $clog2(RW+1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [SHW-1:0]  radicand;
    logic [RW-1:0]   root;
    logic [RW+1:0]   rem;
    logic [CW-1:0]   count;

    logic [RW+1:0]   rem_shift;
    logic [RW+1:0]   trial;
    logic [RW+1:0]   rem_next;
    logic [RW-1:0]   root_next;
    logic            take;

    // One restoring iteration: bring down the next radicand bit pair and
    // subtract 4*root+1 whenever the partial remainder can absorb it.
    always_comb begin
        rem_shift = (rem << 2) | (RW+2)'(radicand[SHW-1 -: 2]);
        trial     = {root, 2'b01};
        take      = (rem_shift >= trial);
        rem_next  = take ? (rem_shift - trial) : rem_shift;
        root_next = (root << 1) | RW'(take);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            radicand  <= '0;
            root      <= '0;
            rem       <= '0;
            count     <= '0;
            root_out  <= '0;
            rem_out   <= '0;
            exact_out <= 1'b1;
            valid_out <= 1'b0;
        end else if (abort_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        radicand <= SHW'(x_in) << (2*FRAC_BITS);
                        root     <= '0;
                        rem      <= '0;
                        count    <= CW'(RW);
                        state    <= CALC;
                    end
                end
                CALC: begin
                    radicand <= radicand << 2;
                    root     <= root_next;
                    rem      <= rem_next;
                    count    <= count - CW'(1);
                    // Final bit: the remainder is bounded by 2*root, so it fits RW+1 bits.
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        root_out  <= root_next;
                        rem_out   <= rem_next[RW:0];
                        exact_out <= (rem_next == '0);
                        valid_out <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        state     <= IDLE;
                        valid_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_out = (state == IDLE);

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: instances with FRAC_BITS 0, 4 and 3 share one
// clock; expected results are queued on accept and drained by a monitor task.
`timescale 1ns/1ps
module tb_sqrt_iter;
    typedef struct {
        longint v;
        int     acc;
        bit     directed;
        int     expRoot;
        int     expRem;
        bit     expExact;
    } exp_t;

    logic        clk_in   = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [11:0] x_i     [3];
    logic        valid_i [3];
    logic        ready_i [3];
    logic        abort_i [3];
    logic        ready_o [3];
    logic        exact_o [3];
    logic        valid_o [3];
    logic [31:0] root_o  [3];
    logic [31:0] rem_o   [3];

    logic [5:0]  root0;
    logic [6:0]  rem0;
    logic [9:0]  root1;
    logic [10:0] rem1;
    logic [8:0]  root2;
    logic [9:0]  rem2;

    int   rwv [3] = '{6, 10, 9};
    int   fbv [3] = '{0, 4, 3};
    exp_t sb  [3][$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   sweepDone = 1'b0;

    assign root_o[0] = 32'(root0);
    assign rem_o[0]  = 32'(rem0);
    assign root_o[1] = 32'(root1);
    assign rem_o[1]  = 32'(rem1);
    assign root_o[2] = 32'(root2);
    assign rem_o[2]  = 32'(rem2);

    sqrt_iter #(.WIDTH(12), .FRAC_BITS(0)) dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .x_in(x_i[0]), .valid_in(valid_i[0]),
        .ready_out(ready_o[0]), .abort_in(abort_i[0]), .root_out(root0), .rem_out(rem0),
        .exact_out(exact_o[0]), .valid_out(valid_o[0]), .ready_in(ready_i[0]));

    sqrt_iter #(.WIDTH(12), .FRAC_BITS(4)) dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .x_in(x_i[1]), .valid_in(valid_i[1]),
        .ready_out(ready_o[1]), .abort_in(abort_i[1]), .root_out(root1), .rem_out(rem1),
        .exact_out(exact_o[1]), .valid_out(valid_o[1]), .ready_in(ready_i[1]));

    sqrt_iter #(.WIDTH(12), .FRAC_BITS(3)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .x_in(x_i[2]), .valid_in(valid_i[2]),
        .ready_out(ready_o[2]), .abort_in(abort_i[2]), .root_out(root2), .rem_out(rem2),
        .exact_out(exact_o[2]), .valid_out(valid_o[2]), .ready_in(ready_i[2]));

    initial forever #5 clk_in = ~clk_in;

    always @(posedge clk_in) cycle <= cycle + 1;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int k, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %0d, expected %0d", name, k, actual, expected);
        end
    endtask

    // Waits for ready_out, presents one request and queues its expected result.
    task automatic applyStimulus(input int k, input logic [11:0] x, input bit directed,
                                 input int r, input int m, input bit ex, output int acc);
        exp_t e;
        int   n = 0;
        while (!ready_o[k] && n < 1000) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (!ready_o[k]) begin
            checks++;
            errors++;
            $display("[TB] FAIL readyTimeout inst%0d: ready_out got 0, expected 1", k);
            acc = -1;
            return;
        end
        x_i[k]     = x;
        valid_i[k] = 1'b1;
        @(posedge clk_in); #1;
        valid_i[k] = 1'b0;
        acc        = cycle;
        e.v        = longint'(x) << (2*fbv[k]);
        e.acc      = acc;
        e.directed = directed;
        e.expRoot  = r;
        e.expRem   = m;
        e.expExact = ex;
        sb[k].push_back(e);
    endtask

    task automatic waitDrain(input int k);
        int n = 0;
        while (sb[k].size() != 0 && n < 2000) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (sb[k].size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout inst%0d: %0d results pending, expected 0", k, sb[k].size());
        end
    endtask

    task automatic waitValid(input int k);
        int n = 0;
        while (!valid_o[k] && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        checkOutput("validTimeout", k, valid_o[k], 1);
    endtask

    task automatic monitor();
        bit   prevV [3] = '{0, 0, 0};
        int   rise  [3] = '{0, 0, 0};
        exp_t e;
        forever begin
            @(negedge clk_in);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n_in) begin
                    prevV[k] = 1'b0;
                end else begin
                    if (valid_o[k] && !prevV[k]) rise[k] = cycle;
                    prevV[k] = valid_o[k];
                    if (valid_o[k] && ready_i[k] && !abort_i[k]) begin
                        if (sb[k].size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpectedResult inst%0d: got valid_out with root %0d, expected none", k, root_o[k]);
                        end else begin
                            e = sb[k].pop_front();
                            checkOutput("latency", k, rise[k] - e.acc, rwv[k]);
                            if (e.directed) begin
                                checkOutput("root", k, root_o[k], e.expRoot);
                                checkOutput("rem", k, rem_o[k], e.expRem);
                                checkOutput("exact", k, exact_o[k], e.expExact);
                            end else begin
                                checkOutput("sumSquares", k, longint'(root_o[k]) * root_o[k] + rem_o[k], e.v);
                                checkOutput("remBound", k, longint'(rem_o[k] <= 2*root_o[k]), 1);
                                checkOutput("exactFlag", k, exact_o[k], longint'(rem_o[k] == 0));
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int acc;
        int acc2;
        for (int k = 0; k < 3; k++) begin
            x_i[k]     = '0;
            valid_i[k] = 1'b0;
            ready_i[k] = 1'b1;
            abort_i[k] = 1'b0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("rstRoot", 0, root_o[0], 0);
        checkOutput("rstRem", 0, rem_o[0], 0);
        checkOutput("rstExact", 0, exact_o[0], 1);
        checkOutput("rstValid", 0, valid_o[0], 0);
        checkOutput("rstReady", 0, ready_o[0], 1);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // Integer roots and back-to-back spacing of RW+2 cycles.
        applyStimulus(0, 12'd0,    1, 0,  0,   1, acc);
        applyStimulus(0, 12'd4095, 1, 63, 126, 0, acc);
        applyStimulus(0, 12'd144,  1, 12, 0,   1, acc);
        applyStimulus(0, 12'd143,  1, 11, 22,  0, acc2);
        checkOutput("b2bSpacing", 0, acc2 - acc, 8);
        applyStimulus(1, 12'd2,    1, 22,   28,   0, acc);
        applyStimulus(1, 12'd4095, 1, 1023, 1791, 0, acc);
        waitDrain(0);
        waitDrain(1);

        // Backpressure: result held while ready_in is low, requests ignored.
        ready_i[0] = 1'b0;
        applyStimulus(0, 12'd100, 1, 10, 0, 1, acc);
        waitValid(0);
        for (int i = 0; i < 5; i++) begin
            valid_i[0] = 1'b1;
            x_i[0]     = 12'(i*7 + 1);
            @(posedge clk_in); #1;
            checkOutput("bpValid", 0, valid_o[0], 1);
            checkOutput("bpRoot", 0, root_o[0], 10);
            checkOutput("bpRem", 0, rem_o[0], 0);
            checkOutput("bpReady", 0, ready_o[0], 0);
        end
        valid_i[0] = 1'b0;
        ready_i[0] = 1'b1;
        @(posedge clk_in); #1;
        checkOutput("bpIdle", 0, ready_o[0], 1);
        checkOutput("bpDrop", 0, valid_o[0], 0);
        waitDrain(0);

        // Abort during the third iteration, with a competing request that must be dropped.
        x_i[0]     = 12'd200;
        valid_i[0] = 1'b1;
        @(posedge clk_in); #1;
        valid_i[0] = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        abort_i[0] = 1'b1;
        valid_i[0] = 1'b1;
        x_i[0]     = 12'd81;
        @(posedge clk_in); #1;
        abort_i[0] = 1'b0;
        valid_i[0] = 1'b0;
        checkOutput("abortReady", 0, ready_o[0], 1);
        checkOutput("abortValid", 0, valid_o[0], 0);
        checkOutput("abortHold", 0, root_o[0], 10);
        repeat (10) @(posedge clk_in);
        #1;
        checkOutput("abortQuiet", 0, valid_o[0], 0);
        applyStimulus(0, 12'd49, 1, 7, 0, 1, acc);
        waitDrain(0);

        // Asynchronous reset in the middle of a computation.
        x_i[0]     = 12'd4095;
        valid_i[0] = 1'b1;
        @(posedge clk_in); #1;
        valid_i[0] = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        #1;
        checkOutput("midRstRoot", 0, root_o[0], 0);
        checkOutput("midRstRem", 0, rem_o[0], 0);
        checkOutput("midRstExact", 0, exact_o[0], 1);
        checkOutput("midRstValid", 0, valid_o[0], 0);
        checkOutput("midRstReady", 0, ready_o[0], 1);
        rst_n_in = 1'b1;
        applyStimulus(0, 12'd143, 1, 11, 22, 0, acc);
        waitDrain(0);

        // Exhaustive sweeps with random consumer stalls.
        fork
            begin
                while (!sweepDone) begin
                    @(posedge clk_in); #1;
                    if (!sweepDone) begin
                        ready_i[0] = ($urandom_range(0, 3) != 0);
                        ready_i[2] = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        join_none
        fork
            begin
                int a;
                for (int x = 0; x < 4096; x++) applyStimulus(0, 12'(x), 0, 0, 0, 0, a);
            end
            begin
                int a;
                for (int x = 0; x < 4096; x++) applyStimulus(2, 12'(x), 0, 0, 0, 0, a);
            end
        join
        sweepDone = 1'b1;
        @(posedge clk_in); #2;
        ready_i[0] = 1'b1;
        ready_i[2] = 1'b1;
        waitDrain(0);
        waitDrain(2);
        repeat (5) @(posedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
